// File: rtl/hex_display_scan.sv
// Time-multiplexed driver for a bank of common-anode 7-segment hex digits with
// leading-zero blanking, per-digit blink and decimal points.
module hex_display_scan #(
    parameter int DIGITS      = 4,
    parameter int CLK_DIV     = 1000,
    parameter int BLINK_SCANS = 250
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4*DIGITS-1:0]   value,
    input  logic                  load,
    input  logic                  blank_lz,
    input  logic [DIGITS-1:0]     blink_mask,
    input  logic [DIGITS-1:0]     dp_in,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [DIGITS-1:0]     an
);

    localparam int PW = $clog2(CLK_DIV);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int BW = (BLINK_SCANS > 1) ? $clog2(BLINK_SCANS) : 1;

    logic [4*DIGITS-1:0] shadow;
    logic [PW-1:0]       presc;
    logic [IW-1:0]       idx;
    logic [BW-1:0]       blink_cnt;
    logic                blink_phase;

    logic                tick;
    logic                scan_end;
    logic [DIGITS-1:0]   upper_zero;
    logic [3:0]          nibble;
    logic                blanked;
    logic [6:0]          glyph;

    assign tick     = (presc == PW'(CLK_DIV - 1));
    assign scan_end = tick && (idx == IW'(DIGITS - 1));

    // upper_zero[i]: nibbles i..DIGITS-1 of the shadow value are all zero
    always_comb begin
        upper_zero = '0;
        upper_zero[DIGITS-1] = (shadow[4*(DIGITS-1) +: 4] == 4'h0);
        for (int i = DIGITS - 2; i >= 0; i--) begin
            upper_zero[i] = upper_zero[i+1] && (shadow[4*i +: 4] == 4'h0);
        end
    end

    assign nibble  = shadow[4*idx +: 4];
    assign blanked = (blank_lz && (idx != '0) && upper_zero[idx])
                   || (blink_mask[idx] && blink_phase);

    always_comb begin
        glyph = 7'h00;
        case (nibble)
            4'h0: glyph = 7'h3F;
            4'h1: glyph = 7'h06;
            4'h2: glyph = 7'h5B;
            4'h3: glyph = 7'h4F;
            4'h4: glyph = 7'h66;
            4'h5: glyph = 7'h6D;
            4'h6: glyph = 7'h7D;
            4'h7: glyph = 7'h07;
            4'h8: glyph = 7'h7F;
            4'h9: glyph = 7'h6F;
            4'hA: glyph = 7'h77;
            4'hB: glyph = 7'h7C;
            4'hC: glyph = 7'h39;
            4'hD: glyph = 7'h5E;
            4'hE: glyph = 7'h79;
            4'hF: glyph = 7'h71;
            default: glyph = 7'h00;
        endcase
    end

    // Outputs are computed from the pre-edge state, so a load coinciding with
    // tick shows the new digit and new shadow together one cycle later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow      <= '0;
            presc       <= '0;
            idx         <= '0;
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
            an          <= '1;
            seg         <= 7'h7F;
            dp          <= 1'b1;
        end else begin
            if (load) begin
                shadow <= value;
            end

            if (tick) begin
                presc <= '0;
            end else begin
                presc <= presc + 1'b1;
            end

            if (tick) begin
                if (idx == IW'(DIGITS - 1)) begin
                    idx <= '0;
                end else begin
                    idx <= idx + 1'b1;
                end
            end

            if (scan_end) begin
                if (blink_cnt == BW'(BLINK_SCANS - 1)) begin
                    blink_cnt   <= '0;
                    blink_phase <= ~blink_phase;
                end else begin
                    blink_cnt <= blink_cnt + 1'b1;
                end
            end

            an  <= ~(DIGITS'(1) << idx);
            seg <= blanked ? 7'h7F : ~glyph;
            dp  <= blanked ? 1'b1 : ~dp_in[idx];
        end
    end

endmodule

// File: tb/tb_hex_display_scan.sv
// Bench for hex_display_scan: directed scenarios plus randomized traffic checked
// against a cycle-count based reference model.
module tb_hex_display_scan;

    localparam int DIGITS      = 4;
    localparam int CLK_DIV     = 4;
    localparam int BLINK_SCANS = 2;

    logic                clk;
    logic                rst_n;
    logic [4*DIGITS-1:0] value;
    logic                load;
    logic                blank_lz;
    logic [DIGITS-1:0]   blink_mask;
    logic [DIGITS-1:0]   dp_in;
    logic [6:0]          seg;
    logic                dp;
    logic [DIGITS-1:0]   an;

    int checks = 0;
    int errors = 0;

    hex_display_scan #(
        .DIGITS(DIGITS), .CLK_DIV(CLK_DIV), .BLINK_SCANS(BLINK_SCANS)
    ) dut (
        .clk(clk), .rst_n(rst_n), .value(value), .load(load),
        .blank_lz(blank_lz), .blink_mask(blink_mask), .dp_in(dp_in),
        .seg(seg), .dp(dp), .an(an)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h at %0t", tag, got, exp, $time);
        end
    endtask

    // reference model: everything follows from cycles elapsed since reset
    logic [6:0] glyph_tbl [16];
    initial begin
        glyph_tbl[0]  = 7'h3F; glyph_tbl[1]  = 7'h06; glyph_tbl[2]  = 7'h5B; glyph_tbl[3]  = 7'h4F;
        glyph_tbl[4]  = 7'h66; glyph_tbl[5]  = 7'h6D; glyph_tbl[6]  = 7'h7D; glyph_tbl[7]  = 7'h07;
        glyph_tbl[8]  = 7'h7F; glyph_tbl[9]  = 7'h6F; glyph_tbl[10] = 7'h77; glyph_tbl[11] = 7'h7C;
        glyph_tbl[12] = 7'h39; glyph_tbl[13] = 7'h5E; glyph_tbl[14] = 7'h79; glyph_tbl[15] = 7'h71;
    end

    int                  m_n;
    logic [4*DIGITS-1:0] m_shadow;
    logic [DIGITS-1:0]   exp_an;
    logic [6:0]          exp_seg;
    logic                exp_dp;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_n      <= 0;
            m_shadow <= '0;
            exp_an   <= '1;
            exp_seg  <= 7'h7F;
            exp_dp   <= 1'b1;
        end else begin
            int d;
            int phase;
            logic blk;
            d     = (m_n / CLK_DIV) % DIGITS;
            phase = (m_n / (CLK_DIV * DIGITS * BLINK_SCANS)) % 2;
            blk   = (blank_lz && d != 0 && (m_shadow >> (4 * d)) == 0)
                 || (blink_mask[d] && phase == 1);
            exp_an  <= ~(DIGITS'(1 << d));
            exp_seg <= blk ? 7'h7F : ~glyph_tbl[(m_shadow >> (4 * d)) & 4'hF];
            exp_dp  <= blk ? 1'b1 : ~dp_in[d];
            m_n     <= m_n + 1;
            if (load) m_shadow <= value;
        end
    end

    // scoreboard against the model on every falling edge
    always @(negedge clk) begin
        check("model_an", 32'(an), 32'(exp_an));
        check("model_seg", 32'(seg), 32'(exp_seg));
        check("model_dp", 32'(dp), 32'(exp_dp));
    end

    // driver tasks
    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_load(input logic [4*DIGITS-1:0] v);
        value = v;
        load  = 1'b1;
        cycle();
        load  = 1'b0;
    endtask

    logic [3:0]  scan_an  [4];
    logic [6:0]  scan_seg [4];
    logic [6:0]  want;
    bit          seen_b;

    initial begin
        scan_an[0] = 4'hE; scan_an[1] = 4'hD; scan_an[2] = 4'hB; scan_an[3] = 4'h7;
        scan_seg[0] = 7'h0E; scan_seg[1] = 7'h30; scan_seg[2] = 7'h08; scan_seg[3] = 7'h79;

        rst_n = 1'b0; value = '0; load = 1'b0;
        blank_lz = 1'b0; blink_mask = '0; dp_in = '0;
        repeat (3) @(negedge clk);
        check("rst_an", 32'(an), 32'hF);
        check("rst_seg", 32'(seg), 32'h7F);
        check("rst_dp", 32'(dp), 32'h1);

        // release and load 1A3F right at the first edge
        rst_n = 1'b1;
        value = 16'h1A3F;
        load  = 1'b1;
        cycle();
        load  = 1'b0;
        check("first_an", 32'(an), 32'hE);
        check("first_seg", 32'(seg), 32'h40);
        for (int e = 2; e <= 17; e++) begin
            cycle();
            check("scan_an", 32'(an), 32'(scan_an[((e - 1) / CLK_DIV) % DIGITS]));
            check("scan_seg", 32'(seg), 32'(scan_seg[((e - 1) / CLK_DIV) % DIGITS]));
        end

        // leading-zero blanking
        blank_lz = 1'b1;
        do_load(16'h0050);
        cycle();
        for (int k = 0; k < 16; k++) begin
            case (an)
                4'hE:    want = 7'h40;
                4'hD:    want = 7'h12;
                default: want = 7'h7F;
            endcase
            check("lz50_seg", 32'(seg), 32'(want));
            cycle();
        end
        do_load(16'h0000);
        cycle();
        for (int k = 0; k < 16; k++) begin
            want = (an == 4'hE) ? 7'h40 : 7'h7F;
            check("lz00_seg", 32'(seg), 32'(want));
            cycle();
        end
        blank_lz = 1'b0;

        // blink on digit 1; other digits always show 8
        blink_mask = 4'b0010;
        do_load(16'h8888);
        cycle();
        for (int k = 0; k < 128; k++) begin
            if (an != 4'hD) check("blink_other", 32'(seg), 32'h00);
            cycle();
        end

        // decimal point on digit 2, then also blinked
        blink_mask = 4'b0000;
        dp_in = 4'b0100;
        cycle();
        for (int k = 0; k < 16; k++) begin
            check("dp_only", 32'(dp), (an == 4'b1011) ? 32'h0 : 32'h1);
            cycle();
        end
        blink_mask = 4'b0100;
        repeat (80) cycle();

        // reset mid-scan while digit 2 is active
        blink_mask = 4'b0000;
        seen_b = 1'b0;
        for (int k = 0; k < 40 && !seen_b; k++) begin
            if (an == 4'hB) seen_b = 1'b1;
            else cycle();
        end
        check("wait_an_b", 32'(an), 32'hB);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_an", 32'(an), 32'hF);
        check("midrst_seg", 32'(seg), 32'h7F);
        check("midrst_dp", 32'(dp), 32'h1);
        @(negedge clk);
        dp_in = 4'b0000;
        rst_n = 1'b1;
        cycle();
        check("restart_an", 32'(an), 32'hE);
        check("restart_seg", 32'(seg), 32'h40);

        // randomized traffic against the model
        for (int k = 0; k < 800; k++) begin
            value      = 16'($urandom);
            if ($urandom_range(0, 3) == 0) value[15:8] = 8'h00;
            if ($urandom_range(0, 3) == 0) value[15:4] = 12'h000;
            load       = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 15) == 0) blank_lz = ~blank_lz;
            if ($urandom_range(0, 31) == 0) blink_mask = 4'($urandom);
            if ($urandom_range(0, 15) == 0) dp_in = 4'($urandom);
            cycle();
        end
        load = 1'b0;
        cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hex_display_scan.md
# hex_display_scan

Parametrised, time-multiplexed driver for a bank of common-anode 7-segment hex digits. It latches a multi-nibble value and scans one digit at a time at a programmable rate. Every digit shows the standard 0–F glyph set on active-low segments. Over a plain per-digit decoder it adds leading-zero blanking, per-digit blink, per-digit decimal points and a load strobe. It sits between the CPU's display/debug register and the board's segment and anode pins.

## Interface
Parameters:
- DIGITS, 4: number of digits scanned; legal range 1..8.
- CLK_DIV, 1000: clock cycles each digit is held active; minimum 2.
- BLINK_SCANS, 250: full scans per blink half-period; minimum 1.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- value  in  4*DIGITS  hex value to show; nibble i drives digit i, digit 0 is rightmost.
- load  in  1  when high at a clock edge, value is copied into the shadow register.
- blank_lz  in  1  enables leading-zero blanking.
- blink_mask  in  DIGITS  bit i high makes digit i blink.
- dp_in  in  DIGITS  bit i high lights the decimal point of digit i.
- seg  out  7  segments {g,f,e,d,c,b,a}; bit0 = a; active-low.
- dp  out  1  decimal point; active-low.
- an  out  DIGITS  digit enables; one-hot, active-low.

## Operation
- Shadow register:
  - Loads from value on any edge where load=1.
  - The display always uses the shadow register, never value directly.
  - blank_lz, blink_mask and dp_in are used live and are not latched.
- Prescaler:
  - Counts 0..CLK_DIV-1 and wraps to 0.
  - tick = (prescaler == CLK_DIV-1).
- Digit index:
  - Advances on tick.
  - Wraps from DIGITS-1 to 0; that wrap event is scan_end.
- Blink:
  - Counter runs 0..BLINK_SCANS-1 and advances on scan_end.
  - On wrap it toggles blink_phase.
- Digit i is blanked when either condition holds:
  - blank_lz=1, i≠0, and shadow nibbles i..DIGITS-1 are all zero. Digit 0 is never blanked by this rule.
  - blink_mask[i]=1 and blink_phase=1.
- Glyph table, active-high before inversion:
  - 0:3F, 1:06, 2:5B, 3:4F, 4:66, 5:6D, 6:7D, 7:07
  - 8:7F, 9:6F, A:77, b:7C, C:39, d:5E, E:79, F:71
  - seg is the bitwise inverse of the glyph.
- Output register, computed every cycle from the current index, shadow register and control inputs:
  - an = ~(1 << index).
  - seg = 7'h7F if the digit is blanked, else the inverted glyph.
  - dp = ~dp_in[index] if not blanked, else 1.
  - A blanked digit keeps its anode asserted; only seg and dp are forced off.

## Timing
- Reset values, applied asynchronously while rst_n=0:
  - Outputs: an = all ones, seg = 7'h7F, dp = 1.
  - Internal state: shadow = 0, prescaler = 0, index = 0, blink counter = 0, blink_phase = 0.
- First rising edge after rst_n rises: an = ~1, showing digit 0.
- Output latency is exactly one cycle from the index, shadow or control change to the seg/an/dp update. A load at edge N is visible on seg at edge N+1 if that digit is active.
- Hold and period lengths:
  - Each digit is active for exactly CLK_DIV cycles.
  - A full scan takes DIGITS*CLK_DIV cycles.
  - Blink half-period is BLINK_SCANS*DIGITS*CLK_DIV cycles.
- load coinciding with tick: the new shadow and the new index both take effect together at the next output update; no glitch glyph is produced.
- DIGITS=1: index stays 0 and scan_end fires every tick.
- rst_n asserted mid-scan immediately forces the reset values, independent of clk.

## Test plan
Bench parameters: DIGITS=4, CLK_DIV=4, BLINK_SCANS=2.
- **Reset:** hold rst_n=0 → an=4'hF, seg=7'h7F, dp=1. Release rst_n → at the first edge an=4'hE, seg=7'h40 (digit 0 shows 0).
- **Load and scan:** load=1 for one cycle with value=16'h1A3F → across one 16-cycle scan the bench sees:
  - an=E, seg=0E
  - an=D, seg=30
  - an=B, seg=08
  - an=7, seg=79
  - Each pair holds for 4 cycles.
- **Leading-zero blanking:** blank_lz=1.
  - Load 16'h0050 → digits 3 and 2 show seg=7F, digit 1 shows 12, digit 0 shows 40.
  - Load 16'h0000 → only digit 0 is lit, with 40.
- **Blink:** blink_mask=4'b0010, value=16'h8888.
  - Digit 1 shows 00 for 32 cycles, then 7F for 32 cycles, repeating.
  - The other digits stay at 00 throughout.
- **Decimal points:** dp_in=4'b0100 → dp=0 only while an=4'b1011. With that digit also blinked, dp=1 during blink_phase=1.
- **Reset mid-scan:** assert rst_n=0 while an=4'hB → outputs return to reset values within the same cycle, without a clock edge. After release the scan restarts at digit 0 with shadow=0.
